led_trace_uart: RTL and testbench
=================================

LED_TRACE_UART -- requirements
Module: led_trace_uart

Interface
REQ-001 SHALL have parameter WIDTH, default 6: width of the traced signal bus.
REQ-002 SHALL have parameter TS_WIDTH, default 32: timestamp width; multiple of 8, range 8..64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: record FIFO entries; power of 2, at least 2.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 469: UART bit period in clk cycles (54 MHz / 115200); at least 2.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port sig_in, input, WIDTH bits: asynchronous signal to trace (e.g. leds).
REQ-008 SHALL have port enable, input, 1 bit: when 1, detected changes are logged.
REQ-009 SHALL have port txd, output, 1 bit: UART 8N1 serial output, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while FIFO is non-empty or the transmitter is active.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a record is dropped.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchroniser; all detection SHALL use the synchronised value s.
REQ-013 SHALL run a free-running TS_WIDTH-bit cycle counter ts from 0 after reset, wrapping at its maximum to 0 without any flag.
REQ-014 SHALL treat the first s sample after reset as a change (valid flag cleared at reset) and log it if enable=1.
REQ-015 SHALL, when s differs from prev, push {ts, s} into the FIFO in the same cycle; prev updates every cycle regardless of enable.
REQ-016 SHALL make the latency from a sig_in edge to the FIFO push exactly 3 clk cycles.
REQ-017 SHALL, when a push arrives with the FIFO full and no pop in that cycle, drop the record and set overflow; a simultaneous pop and push on a full FIFO SHALL accept the push.
REQ-018 SHALL use a transmit FSM with states IDLE, LOAD, START, DATA, STOP: IDLE->LOAD when the FIFO is non-empty; LOAD pops one record and latches it; START/DATA/STOP send one byte; STOP->START for the next byte, or STOP->IDLE after the last byte.
REQ-019 SHALL frame each record as: sync byte 0xA5, then TS_WIDTH/8 timestamp bytes MSB first, then ceil(WIDTH/8) value bytes MSB first, zero-padded.
REQ-020 SHALL send each byte as a start bit (0), 8 data bits LSB first, and a stop bit (1), each bit CLKS_PER_BIT cycles long.
REQ-021 SHALL drive the start bit on txd within 2 cycles of the FIFO becoming non-empty while in IDLE.
REQ-022 SHALL send records back-to-back with no idle bits between bytes or between records.

Reset
REQ-023 SHALL, on rst_n=0, immediately set txd=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, ts=0, synchronisers=0, valid flag=0.
REQ-024 SHALL abandon any in-flight frame on reset mid-byte, with txd returning high asynchronously.
REQ-025 SHALL clear overflow only by reset.

Configuration
REQ-026 SHALL, with TRACE_OVF_MARK_EN defined, send 0x5A instead of 0xA5 as the sync byte of the first record pushed after any dropped record, then revert to 0xA5.
REQ-027 SHALL, without TRACE_OVF_MARK_EN defined, always send 0xA5; the drop is then signalled only on overflow.

Verification (bench parameters: WIDTH=6, TS_WIDTH=16, FIFO_DEPTH=4, CLKS_PER_BIT=4)
REQ-028 SHALL verify: release reset with sig_in=6'h00 and enable=1 -> one record A5 00 03 00 decoded on txd; overflow=0.
REQ-029 SHALL verify: change sig_in to 6'h2A at ts=100 -> record A5 00 67 2A (timestamp = 100+3).
REQ-030 SHALL verify: apply 6 changes, 1 cycle apart, while the transmitter is busy -> the first 5 records are sent in order (4 queued plus the one latched by LOAD), the 6th is dropped, and overflow=1 until reset.
REQ-031 SHALL verify the overflow marker: with TRACE_OVF_MARK_EN, the next change after the drop is sent with sync 5A and the one after with A5; without the macro, both are sent with A5.
REQ-032 SHALL verify: assert rst_n=0 during the DATA state of byte 2 -> txd=1 in the same cycle, busy=0; after release, a fresh record with ts=3 is sent.
REQ-033 SHALL verify: with enable=0, toggle sig_in -> txd stays 1 and busy=0; after setting enable=1, the next change is logged.

Source files
------------

// File: rtl/led_trace_uart.sv
// led_trace_uart: timestamps every change of a synchronised input bus and streams
// {sync, ts, value} records over UART 8N1. Define TRACE_OVF_MARK_EN to send sync 0x5A after a drop.
module led_trace_uart #(
    parameter int WIDTH        = 6,
    parameter int TS_WIDTH     = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 469
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig_in,
    input  logic             enable,
    output logic             txd,
    output logic             busy,
    output logic             overflow
);
    localparam int VB = (WIDTH + 7) / 8;
    localparam int NB = 1 + TS_WIDTH / 8 + VB;
    localparam int FW = NB * 8;
    localparam int EW = 1 + TS_WIDTH + WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t              state;
    logic [WIDTH-1:0]    s1, s, s_d, prev;
    logic [2:0]          vld_pipe;
    logic                prev_vld;
    logic [TS_WIDTH-1:0] ts;
    logic                chg, push, pop, wr_en, drop, empty, full, mark_pend;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [EW-1:0]       rd_entry;
    logic [VB*8-1:0]     val_pad;
    logic [7:0]          sync_byte, cur_byte;
    logic [FW-1:0]       frame;
    logic [CW-1:0]       clk_cnt;
    logic [2:0]          bit_idx;
    logic [BW-1:0]       byte_cnt;
    logic                last_byte;

    // s_d is one stage past the synchroniser so the push lands 3 cycles after the input edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s        <= '0;
            s_d      <= '0;
            prev     <= '0;
            vld_pipe <= '0;
            prev_vld <= 1'b0;
            ts       <= '0;
        end else begin
            s1       <= sig_in;
            s        <= s1;
            s_d      <= s;
            prev     <= s_d;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
            prev_vld <= vld_pipe[2];
            ts       <= ts + TS_WIDTH'(1);
        end
    end

    assign chg   = vld_pipe[2] && (!prev_vld || (s_d != prev));
    assign push  = chg && enable;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = (state == LOAD);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign busy  = !empty || (state != IDLE);

`ifdef TRACE_OVF_MARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mark_pend <= 1'b0;
        else if (drop)  mark_pend <= 1'b1;
        else if (wr_en) mark_pend <= 1'b0;
    end
`else
    assign mark_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {mark_pend, ts, s_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop)  overflow <= 1'b1;
        end
    end

    assign rd_entry  = mem[rd_ptr[AW-1:0]];
    assign val_pad   = (VB*8)'(rd_entry[WIDTH-1:0]);
    assign sync_byte = rd_entry[EW-1] ? 8'h5A : 8'hA5;
    assign cur_byte  = frame[FW-1 -: 8];
    assign last_byte = (byte_cnt == BW'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            txd      <= 1'b1;
            frame    <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    frame    <= {sync_byte, rd_entry[EW-2 -: TS_WIDTH], val_pad};
                    byte_cnt <= '0;
                    clk_cnt  <= '0;
                    txd      <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= cur_byte[0];
                        state   <= DATA;
                    end else clk_cnt <= clk_cnt + CW'(1);
                end
                DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= cur_byte[bit_idx + 3'd1];
                        end
                    end else clk_cnt <= clk_cnt + CW'(1);
                end
                STOP: begin
                    // LOAD occupies the final stop-bit cycle so queued records follow with no gap
                    if (last_byte && !empty && clk_cnt == CW'(CLKS_PER_BIT - 2)) begin
                        clk_cnt <= '0;
                        state   <= LOAD;
                    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (last_byte) state <= IDLE;
                        else begin
                            frame    <= frame << 8;
                            byte_cnt <= byte_cnt + BW'(1);
                            txd      <= 1'b0;
                            state    <= START;
                        end
                    end else clk_cnt <= clk_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_trace_uart.sv
// Bench for led_trace_uart: decodes txd into bytes and compares records against a timestamp model.
module tb_led_trace_uart;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] sig_in = '0;
    logic       enable = 1'b1;
    logic       txd, busy, overflow;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    logic [5:0] cur = '0;

    led_trace_uart #(.WIDTH(6), .TS_WIDTH(16), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .txd(txd), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // cyc mirrors the expected timestamp: zero at reset, +1 per rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // UART receiver sampling mid-bit on falling edges
    initial begin
        bit         act;
        int         k;
        logic [7:0] sh;
        act = 0; k = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) act = 0;
            else if (!act) begin
                if (txd === 1'b0) begin act = 1; k = 0; end
            end else begin
                k++;
                if (k >= CPB + CPB/2 && k <= 8*CPB + CPB/2 && (k % CPB) == CPB/2)
                    sh[(k - CPB - CPB/2) / CPB] = txd;
                if (k == 9*CPB + CPB/2) begin
                    if (txd !== 1'b1) rx_ferr++;
                    rx_q.push_back(sh);
                    act = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rec(input logic [7:0] sync, input int t, input logic [5:0] v);
        return {sync, 16'(t), 2'b00, v};
    endfunction

    function automatic logic [5:0] nxt(input logic [5:0] v);
        return v ^ 6'($urandom_range(1, 63));
    endfunction

    task automatic drive(input logic [5:0] v, output int t);
        @(negedge clk);
        sig_in = v;
        cur    = v;
        t      = cyc;
    endtask

    task automatic get_rec(input string tag, input logic [31:0] exp);
        int n;
        logic [31:0] r;
        n = 0;
        while (rx_q.size() < 4 && n < 800) begin @(negedge clk); n++; end
        if (rx_q.size() < 4) chk({tag, "_timeout"}, rx_q.size(), 4);
        else begin
            r = {rx_q.pop_front(), rx_q.pop_front(), rx_q.pop_front(), rx_q.pop_front()};
            chk(tag, r, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (busy !== 1'b0) chk(tag, busy, 0);
    endtask

    initial begin
        int t, t0, n;
        bit act;
        logic [5:0] bv[6];
        logic [7:0] mark;

        // reset state
        #12;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // first sample logged at ts=3; change at ts=100 queued behind it
        while (cyc < 100) @(negedge clk);
        sig_in = 6'h2A; cur = 6'h2A;
        get_rec("first_rec", 32'hA5_00_03_00);
        chk("ovf_after_first", overflow, 0);
        get_rec("rec_ts100", 32'hA5_00_67_2A);

        // random changes with random spacing
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(2, 40)) @(negedge clk);
            drive(nxt(cur), t);
            get_rec($sformatf("rand_rec%0d", i), rec(8'hA5, t + 3, cur));
        end

        // burst of 6 back-to-back changes: 5 kept, 6th dropped
        wait_idle("idle_before_burst");
        for (int i = 0; i < 6; i++) begin
            bv[i] = nxt(cur);
            drive(bv[i], t);
            if (i == 0) t0 = t;
        end
        for (int i = 0; i < 5; i++)
            get_rec($sformatf("burst_rec%0d", i), rec(8'hA5, t0 + i + 3, bv[i]));
        wait_idle("idle_after_burst");
        chk("ovf_after_burst", overflow, 1);

`ifdef TRACE_OVF_MARK_EN
        mark = 8'h5A;
`else
        mark = 8'hA5;
`endif
        drive(nxt(cur), t);
        get_rec("mark_rec", rec(mark, t + 3, cur));
        drive(nxt(cur), t);
        get_rec("post_mark_rec", rec(8'hA5, t + 3, cur));
        chk("ovf_sticky", overflow, 1);

        // enable=0: changes ignored
        wait_idle("idle_before_dis");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(nxt(cur), t);
            repeat (4) @(negedge clk);
        end
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) act = 1;
        end
        chk("dis_activity", {31'd0, act}, 0);
        chk("dis_rx_empty", rx_q.size(), 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        drive(nxt(cur), t);
        get_rec("reenable_rec", rec(8'hA5, t + 3, cur));

        // reset during DATA of the second byte
        wait_idle("idle_before_midrst");
        drive(nxt(cur), t);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (10*CPB + 3*CPB) @(negedge clk);
        chk("busy_before_midrst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", overflow, 0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        rst_n = 1'b1;
        get_rec("post_rst_rec", rec(8'hA5, 3, cur));

        chk("frame_err", rx_ferr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
